// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
// Shared frame-format definitions for the serial frame sender and the
// sequence-detecting receiver. Both ends import this package, so they agree
// on the preamble, the field widths and the state names.
//   state_e          : frame phase (IDLE, PRE, LEN, PAY, PAR)
//   PREAMBLE_DEFAULT : start pattern, sent MSB first
//   LEN_W / DATA_W   : length-field width and payload register width
//   framePar         : even parity over the length field and the used payload bits
package serial_frame_pkg;

  localparam int LEN_W = 4;
  localparam int DATA_W = 15;
  localparam logic [3:0] PREAMBLE_DEFAULT = 4'b1101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    LEN  = 3'd2,
    PAY  = 3'd3,
    PAR  = 3'd4
  } state_e;

  // XOR of all four length bits and payload bits [len-1:0]. Payload bits
  // above the length are not transmitted, so they do not count.
  function automatic logic framePar(input logic [LEN_W-1:0] len,
                                    input logic [DATA_W-1:0] data);
    logic p;
    p = ^len;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len)) begin
        p = p ^ data[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// frame_bit_counter
// Loadable down-counter holding the index of the bit currently on the wire.
// It is reloaded at each field boundary and reused for the PRE, LEN and PAY
// fields.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   load    : load loadVal (has priority over en)
//   loadVal : value to load
//   en      : decrement by one; saturates at zero
//   count   : current index
//   isZero  : count == 0, i.e. the current bit is the last of its field
module frame_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         isZero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/serial_frame_sender.sv
// serial_frame_sender
// Parallel-to-serial frame generator: PREAMBLE (4 bits, MSB first), then the
// 4-bit length field (MSB first), then `length` payload bits from
// dataIn[length-1] down to dataIn[0]. One bit is advanced per clkEn pulse.
// Optional: define SERIAL_PARITY_EN to append one even-parity bit (PAR state)
// covering the length field and the payload bits.
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset; aborts a frame with no done pulse
//   clkEn       : single-cycle step pulse
//   start       : frame request, sampled only in IDLE
//   length      : payload bit count, latched at start
//   dataIn      : payload, latched at start
//   serOut      : serial bit (registered)
//   serOutValid : serOut carries a payload bit
//   busy        : frame in progress
//   done        : one-cycle pulse at frame end, coincident with busy falling
//   countOut    : payload bits not yet presented, including the current one
//   stateDbg    : current FSM state, for observation only
//
// Handshake: start is a request, busy is the acknowledge. A request is taken
// on any edge where the FSM is IDLE and start is high; while busy is high,
// start is ignored. The edge that accepts a frame never also consumes clkEn.
module serial_frame_sender
  import serial_frame_pkg::*;
#(
  parameter logic [3:0] PREAMBLE = PREAMBLE_DEFAULT,
  parameter int         MAX_LEN  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] dataIn,
  output logic              serOut,
  output logic              serOutValid,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  countOut,
  output state_e            stateDbg
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  state_e            state;
  logic [LEN_W-1:0]  lenReg;
  logic [DATA_W-1:0] dataReg;
`ifdef SERIAL_PARITY_EN
  logic              parityReg;
`endif

  logic [LEN_W-1:0]  lenIn;
  logic [LEN_W-1:0]  bitIdx;
  logic [LEN_W-1:0]  nextIdx;
  logic              bitIsZero;
  logic              cntLoad;
  logic [LEN_W-1:0]  cntLoadVal;
  logic              cntEn;
  logic              payloadDone;

  // A builder with a shorter maximum frame clips longer requests.
  assign lenIn   = (length > MAX_LEN_C) ? MAX_LEN_C : length;
  assign nextIdx = bitIdx - 1'b1;

  // The step that leaves the payload: last payload bit sent, or an empty
  // payload right after length[0].
  assign payloadDone = clkEn && bitIsZero &&
                       ((state == PAY) || ((state == LEN) && (lenReg == '0)));

  // Counter control: reload at every field boundary, otherwise count down.
  always_comb begin
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntEn      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cntLoad    = 1'b1;
          cntLoadVal = LEN_W'(3);
        end
      end
      PRE: begin
        if (clkEn) begin
          if (bitIsZero) begin
            cntLoad    = 1'b1;
            cntLoadVal = LEN_W'(3);
          end else begin
            cntEn = 1'b1;
          end
        end
      end
      LEN: begin
        if (clkEn) begin
          if (bitIsZero) begin
            if (lenReg != '0) begin
              cntLoad    = 1'b1;
              cntLoadVal = lenReg - 1'b1;
            end
          end else begin
            cntEn = 1'b1;
          end
        end
      end
      PAY: begin
        if (clkEn && !bitIsZero) begin
          cntEn = 1'b1;
        end
      end
      default: begin
        cntLoad = 1'b0;
      end
    endcase
  end

  frame_bit_counter #(
    .W(LEN_W)
  ) u_bitCounter (
    .clk    (clk),
    .rst    (rst),
    .load   (cntLoad),
    .loadVal(cntLoadVal),
    .en     (cntEn),
    .count  (bitIdx),
    .isZero (bitIsZero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lenReg      <= '0;
      dataReg     <= '0;
`ifdef SERIAL_PARITY_EN
      parityReg   <= 1'b0;
`endif
      serOut      <= 1'b0;
      serOutValid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      countOut    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= PRE;
            lenReg      <= lenIn;
            dataReg     <= dataIn;
`ifdef SERIAL_PARITY_EN
            parityReg   <= framePar(lenIn, dataIn);
`endif
            serOut      <= PREAMBLE[3];
            serOutValid <= 1'b0;
            busy        <= 1'b1;
            countOut    <= '0;
          end
        end

        PRE: begin
          if (clkEn) begin
            if (!bitIsZero) begin
              serOut <= PREAMBLE[nextIdx[1:0]];
            end else begin
              state  <= LEN;
              serOut <= lenReg[3];
            end
          end
        end

        LEN: begin
          if (clkEn && !bitIsZero) begin
            serOut <= lenReg[nextIdx[1:0]];
          end else if (clkEn && (lenReg != '0)) begin
            state       <= PAY;
            serOut      <= dataReg[lenReg - 1'b1];
            serOutValid <= 1'b1;
            countOut    <= lenReg;
          end
        end

        PAY: begin
          if (clkEn && !bitIsZero) begin
            serOut   <= dataReg[nextIdx];
            // Remaining bits including the new current one is nextIdx + 1.
            countOut <= bitIdx;
          end
        end

        PAR: begin
          if (clkEn) begin
            state       <= IDLE;
            serOut      <= 1'b0;
            serOutValid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            countOut    <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Leaving the payload overrides whatever the LEN/PAY arms set above.
      if (payloadDone) begin
`ifdef SERIAL_PARITY_EN
        state       <= PAR;
        serOut      <= parityReg;
        serOutValid <= 1'b0;
        countOut    <= '0;
`else
        state       <= IDLE;
        serOut      <= 1'b0;
        serOutValid <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        countOut    <= '0;
`endif
      end
    end
  end

  assign stateDbg = state;

endmodule

// File: tb/tb_serial_frame_sender.sv
// tb_serial_frame_sender
// Bench for serial_frame_sender. A frame model builds the expected sequence of
// {serOut, serOutValid, busy, done, countOut} snapshots straight from the
// frame format; each test drives frames and compares snapshots inline.
module tb_serial_frame_sender;
  import serial_frame_pkg::*;

`ifdef SERIAL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clkEn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  length = '0;
  logic [14:0] dataIn = '0;
  logic        serOut;
  logic        serOutValid;
  logic        busy;
  logic        done;
  logic [3:0]  countOut;
  state_e      stateDbg;

  always #5 clk = ~clk;

  serial_frame_sender dut (
    .clk        (clk),
    .rst        (rst),
    .clkEn      (clkEn),
    .start      (start),
    .length     (length),
    .dataIn     (dataIn),
    .serOut     (serOut),
    .serOutValid(serOutValid),
    .busy       (busy),
    .done       (done),
    .countOut   (countOut),
    .stateDbg   (stateDbg)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  function automatic logic [7:0] snap();
    return {serOut, serOutValid, busy, done, countOut};
  endfunction

  // Expected snapshots: one after acceptance, one after each clkEn pulse
  // (the last being the done cycle), plus one idle cycle if tail is set.
  task automatic model_frame(input logic [3:0] len, input logic [14:0] data, input bit tail);
    bit bits[$];
    logic [3:0] pre;
    int n;
    bit par;
    n = int'(len);
    pre = 4'b1101;
    for (int i = 3; i >= 0; i--) bits.push_back(pre[i]);
    for (int i = 3; i >= 0; i--) bits.push_back(len[i]);
    par = 1'b0;
    for (int i = 0; i < 4; i++) par = par ^ len[i];
    for (int i = n - 1; i >= 0; i--) begin
      bits.push_back(data[i]);
      par = par ^ data[i];
    end
    if (PAR_BITS == 1) bits.push_back(par);
    for (int k = 0; k < bits.size(); k++) begin
      bit pay;
      pay = (k >= 8) && (k < 8 + n);
      exp_q.push_back({bits[k], pay, 1'b1, 1'b0, pay ? 4'(8 + n - k) : 4'd0});
    end
    exp_q.push_back(8'b0001_0000);
    if (tail) exp_q.push_back(8'h00);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after a falling edge.
  task automatic drive_frame(input logic [3:0] len, input logic [14:0] data,
                             input bit disturb, input bit startWithEn, input bit tail);
    int n;
    n = 8 + int'(len) + PAR_BITS;
    length = len;
    dataIn = data;
    start = 1'b1;
    clkEn = startWithEn;
    @(negedge clk);
    start = 1'b0;
    clkEn = 1'b0;
    if (disturb) begin
      length = 4'($urandom);
      dataIn = 15'($urandom);
    end
    obs_q.push_back(snap());
    for (int p = 0; p < n; p++) begin
      repeat ($urandom_range(0, 2)) begin
        start = disturb;
        @(negedge clk);
      end
      clkEn = 1'b1;
      start = disturb && (p != n - 1);
      if (disturb) dataIn = 15'($urandom);
      @(negedge clk);
      clkEn = 1'b0;
      start = 1'b0;
      obs_q.push_back(snap());
    end
    if (tail) begin
      @(negedge clk);
      obs_q.push_back(snap());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (snap() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b", snap(), 8'h00);
    end
    vectors++;
    if (stateDbg !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected %0d", stateDbg, IDLE);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len3();
    exp_q.delete(); obs_q.delete();
    model_frame(4'd3, 15'b101, 1'b1);
    drive_frame(4'd3, 15'b101, 1'b0, 1'b0, 1'b1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL len3 step %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_len0();
    exp_q.delete(); obs_q.delete();
    model_frame(4'd0, 15'h5A5A, 1'b1);
    drive_frame(4'd0, 15'h5A5A, 1'b0, 1'b0, 1'b1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL len0 step %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_q.delete(); obs_q.delete();
    model_frame(4'd15, 15'h7FFF, 1'b1);
    drive_frame(4'd15, 15'h7FFF, 1'b1, 1'b0, 1'b1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ignore_start step %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_with_en();
    logic [3:0] len;
    logic [14:0] data;
    len = 4'($urandom_range(1, 15));
    data = 15'($urandom);
    exp_q.delete(); obs_q.delete();
    model_frame(len, data, 1'b1);
    drive_frame(len, data, 1'b0, 1'b1, 1'b1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL start_with_en step %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_hold();
    length = 4'd6;
    dataIn = 15'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (snap() !== 8'b1010_0000) begin
        miscompares++;
        $display("FAIL hold: got %b expected %b", snap(), 8'b1010_0000);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    length = 4'd5;
    dataIn = 15'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Walk into the payload: 8 pulses reach the first payload bit, 2 more
    // put the frame on payload bit 2.
    repeat (10) begin
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
    end
    vectors++;
    if (serOutValid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_precond: got valid %b expected %b", serOutValid, 1'b1);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (snap() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %b expected %b", snap(), 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      clkEn = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_mid_after cycle %0d: got busy/done %b expected %b", c, {busy, done}, 2'b00);
      end
    end
    clkEn = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] la, lb;
    logic [14:0] da, db;
    la = 4'($urandom);
    lb = 4'($urandom);
    da = 15'($urandom);
    db = 15'($urandom);
    exp_q.delete(); obs_q.delete();
    model_frame(la, da, 1'b0);
    model_frame(lb, db, 1'b1);
    drive_frame(la, da, 1'b0, 1'b0, 1'b0);
    drive_frame(lb, db, 1'b0, 1'b0, 1'b1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    exp_q.delete(); obs_q.delete();
    model_frame(4'd2, 15'b11, 1'b1);
    drive_frame(4'd2, 15'b11, 1'b0, 1'b0, 1'b1);
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL parity step %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      logic [3:0] len;
      logic [14:0] data;
      bit disturb, withEn;
      len = 4'($urandom);
      data = 15'($urandom);
      disturb = 1'($urandom_range(0, 1));
      withEn = 1'($urandom_range(0, 1));
      exp_q.delete(); obs_q.delete();
      model_frame(len, data, 1'b1);
      drive_frame(len, data, disturb, withEn, 1'b1);
      foreach (exp_q[i]) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random frame %0d len %0d step %0d: got %b expected %b",
                   f, len, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_len3();
    test_len0();
    test_ignore_start();
    test_start_with_en();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
